// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: width codes, fault codes, FSM states.
package load_store_unit_pkg;

  // RV32I funct3 width/sign codes
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    FaultNone     = 2'b00,
    FaultMisalign = 2'b01,
    FaultIllegal  = 2'b10,
    FaultTimeout  = 2'b11
  } fault_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StResp = 2'b10
  } state_e;

  // Decode-time legality check; illegal encodings take priority over alignment.
  function automatic fault_e lsu_check(input logic [2:0] funct3, input logic is_store,
                                       input logic [1:0] addr_lo);
    fault_e f;
    f = FaultNone;
    if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111 || (funct3[2] && is_store)) begin
      f = FaultIllegal;
    end else if ((funct3[1:0] == 2'b01 && addr_lo[0]) ||
                 (funct3 == LSU_W && addr_lo != 2'b00)) begin
      f = FaultMisalign;
    end
    return f;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane steering for stores and lane extraction/extension for loads.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte/half from the read word
  always_comb begin
    w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
  end

  // Steer store lanes and extend load data by access size; funct3[2] selects zero-extension
  always_comb begin
    o_wdata     = i_store_data;
    o_wstrb     = 4'b1111;
    o_load_data = i_rdata;
    unique case (i_funct3[1:0])
      2'b00: begin
        o_wdata     = {4{i_store_data[7:0]}};
        o_wstrb     = 4'b0001 << i_addr_lo;
        o_load_data = i_funct3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      2'b01: begin
        o_wdata     = {2{i_store_data[15:0]}};
        o_wstrb     = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_load_data = i_funct3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: begin
        o_wdata     = i_store_data;
        o_wstrb     = 4'b1111;
        o_load_data = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one req/ack transaction per accepted start, with
// alignment/legality checking, optional request timeout and registered outputs.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_load_data,
  output logic        o_fault,
  output logic [1:0]  o_fault_code,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_wstrb,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  state_e      r_state;
  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_timer;
  logic        r_busy;
  logic        r_done;
  logic        r_fault;
  fault_e      r_fault_code;
  logic [31:0] r_load_data;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_wstrb;
  logic [31:0] r_mem_wdata;

  logic [2:0]  w_funct3;
  logic [1:0]  w_addr_lo;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [31:0] w_load;
  fault_e      w_chk;

  // Idle steers the incoming request; afterwards the captured access drives load extraction
  always_comb begin
    w_funct3  = (r_state == StIdle) ? i_funct3   : r_funct3;
    w_addr_lo = (r_state == StIdle) ? i_addr[1:0] : r_addr_lo;
    w_chk     = lsu_check(i_funct3, i_is_store, i_addr[1:0]);
  end

  load_store_unit_align u_align (
    .i_funct3     (w_funct3),
    .i_addr_lo    (w_addr_lo),
    .i_store_data (i_store_data),
    .i_rdata      (i_mem_rdata),
    .o_wdata      (w_wdata),
    .o_wstrb      (w_wstrb),
    .o_load_data  (w_load)
  );

  // Access FSM with capture, timeout counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_is_store   <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr_lo    <= 2'b00;
      r_timer      <= 32'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= FaultNone;
      r_load_data  <= 32'd0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wstrb  <= 4'b0000;
      r_mem_wdata  <= 32'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_is_store <= i_is_store;
            r_funct3   <= i_funct3;
            r_addr_lo  <= i_addr[1:0];
            r_busy     <= 1'b1;
            if (w_chk != FaultNone) begin
              // Rejected accesses never reach memory
              r_state      <= StResp;
              r_done       <= 1'b1;
              r_fault      <= 1'b1;
              r_fault_code <= w_chk;
              r_load_data  <= 32'd0;
            end else begin
              r_state     <= StReq;
              r_timer     <= 32'd0;
              r_mem_req   <= 1'b1;
              r_mem_we    <= i_is_store;
              r_mem_addr  <= {i_addr[31:2], 2'b00};
              r_mem_wstrb <= i_is_store ? w_wstrb : 4'b0000;
              r_mem_wdata <= i_is_store ? w_wdata : 32'd0;
            end
          end
        end
        StReq: begin
          if (i_mem_ack) begin
            r_state      <= StResp;
            r_mem_req    <= 1'b0;
            r_done       <= 1'b1;
            r_fault      <= 1'b0;
            r_fault_code <= FaultNone;
            if (!r_is_store) r_load_data <= w_load;
          end else if (TIMEOUT != 0 && r_timer == TIMEOUT - 1) begin
            r_state      <= StResp;
            r_mem_req    <= 1'b0;
            r_done       <= 1'b1;
            r_fault      <= 1'b1;
            r_fault_code <= FaultTimeout;
            r_load_data  <= 32'd0;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        StResp: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Drive ports straight from registers
  always_comb begin
    o_busy       = r_busy;
    o_done       = r_done;
    o_fault      = r_fault;
    o_fault_code = r_fault_code;
    o_load_data  = r_load_data;
    o_mem_req    = r_mem_req;
    o_mem_we     = r_mem_we;
    o_mem_addr   = r_mem_addr;
    o_mem_wstrb  = r_mem_wstrb;
    o_mem_wdata  = r_mem_wdata;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: scoreboard of expected completions,
// bench-side memory responder with programmable ack delay.
module tb_load_store_unit;

  localparam int unsigned Tmo = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_is_store = 1'b0;
  logic [2:0]  i_funct3 = 3'b000;
  logic [31:0] i_addr = 32'd0;
  logic [31:0] i_store_data = 32'd0;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_load_data;
  logic        o_fault;
  logic [1:0]  o_fault_code;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_wstrb;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = 32'd0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(Tmo)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_is_store   (i_is_store),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_store_data (i_store_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_load_data  (o_load_data),
    .o_fault      (o_fault),
    .o_fault_code (o_fault_code),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wstrb  (o_mem_wstrb),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_ack    (i_mem_ack),
    .i_mem_rdata  (i_mem_rdata)
  );

  typedef struct {
    logic [31:0] data;
    logic        fault;
    logic [1:0]  code;
    int          lat;
    int          reqs;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_ld = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access: ack_dly = REQ cycles waited before ack (-1 = never ack)
  task automatic op(input string name, input bit st, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                    input int ack_dly, input logic [31:0] exp_ld, input logic [1:0] exp_code,
                    input logic [31:0] exp_maddr, input logic [3:0] exp_strb,
                    input logic [31:0] exp_wdata, input bit poke_busy);
    exp_t e;
    exp_t got_e;
    int   cyc;
    int   req_n;
    bit   seen;
    e.code  = exp_code;
    e.fault = (exp_code != 2'b00);
    if (e.fault) e.data = 32'd0;
    else if (st) e.data = last_ld;
    else e.data = exp_ld;
    last_ld = e.data;
    if (exp_code == 2'b11) begin
      e.lat = 1 + Tmo; e.reqs = Tmo;
    end else if (e.fault) begin
      e.lat = 1; e.reqs = 0;
    end else begin
      e.lat = 2 + ack_dly; e.reqs = ack_dly + 1;
    end
    @(negedge clk);
    i_start = 1'b1; i_is_store = st; i_funct3 = f3; i_addr = addr; i_store_data = sd;
    sb_q.push_back(e);
    @(negedge clk);
    i_start = 1'b0;
    cyc = 1; req_n = 0; seen = 0;
    while (cyc <= 40 && !seen) begin
      if (o_done) begin
        seen = 1;
      end else begin
        if (o_mem_req) begin
          check_eq({name, "/mem_addr"}, o_mem_addr, exp_maddr);
          check_eq({name, "/mem_we"}, o_mem_we, st);
          check_eq({name, "/mem_wstrb"}, o_mem_wstrb, st ? exp_strb : 4'b0000);
          check_eq({name, "/mem_wdata"}, o_mem_wdata, st ? exp_wdata : 32'd0);
          if (ack_dly >= 0 && req_n == ack_dly) begin
            i_mem_ack = 1'b1; i_mem_rdata = rdata;
          end else begin
            i_mem_ack = 1'b0; i_mem_rdata = 32'hFFFF_FFFF;
          end
          req_n++;
        end else begin
          i_mem_ack = 1'b0;
        end
        if (poke_busy && cyc == 2) begin
          i_start = 1'b1; i_is_store = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0000_0300;
        end else begin
          i_start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    i_mem_ack = 1'b0;
    i_start = 1'b0;
    got_e = sb_q.pop_front();
    if (!seen) begin
      check_eq({name, "/done_bound"}, o_done, 1'b1);
    end else begin
      check_eq({name, "/latency"}, cyc, got_e.lat);
      check_eq({name, "/req_cycles"}, req_n, got_e.reqs);
      check_eq({name, "/load_data"}, o_load_data, got_e.data);
      check_eq({name, "/fault"}, o_fault, got_e.fault);
      check_eq({name, "/fault_code"}, o_fault_code, got_e.code);
      check_eq({name, "/busy_at_done"}, o_busy, 1'b1);
      check_eq({name, "/req_at_done"}, o_mem_req, 1'b0);
      // start during the done cycle must be dropped
      i_start = 1'b1; i_is_store = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0000_0300;
      @(negedge clk);
      i_start = 1'b0;
      check_eq({name, "/idle_busy"}, o_busy, 1'b0);
      check_eq({name, "/idle_req"}, o_mem_req, 1'b0);
      check_eq({name, "/done_pulse"}, o_done, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    #12;
    check_eq("rst/busy", o_busy, 1'b0);
    check_eq("rst/done", o_done, 1'b0);
    check_eq("rst/fault", o_fault, 1'b0);
    check_eq("rst/fault_code", o_fault_code, 2'b00);
    check_eq("rst/load_data", o_load_data, 32'd0);
    check_eq("rst/mem_req", o_mem_req, 1'b0);
    check_eq("rst/mem_we", o_mem_we, 1'b0);
    check_eq("rst/mem_addr", o_mem_addr, 32'd0);
    check_eq("rst/mem_wstrb", o_mem_wstrb, 4'b0000);
    check_eq("rst/mem_wdata", o_mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //  name     st  f3      addr          sd            rdata         dly exp_ld        code   maddr         strb     wdata       poke
    op("lw",    0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 2'b00, 32'h0000_0100, 4'b0000, 32'h0,        0);
    op("lb",    0, 3'b000, 32'h0000_0103, 32'h0,        32'h80112233, 0, 32'hFFFFFF80, 2'b00, 32'h0000_0100, 4'b0000, 32'h0,        0);
    op("lbu",   0, 3'b100, 32'h0000_0103, 32'h0,        32'h80112233, 0, 32'h00000080, 2'b00, 32'h0000_0100, 4'b0000, 32'h0,        0);
    op("lhu",   0, 3'b101, 32'h0000_0102, 32'h0,        32'h80112233, 0, 32'h00008011, 2'b00, 32'h0000_0100, 4'b0000, 32'h0,        0);
    op("lh_w2", 0, 3'b001, 32'h0000_0102, 32'h0,        32'h80112233, 2, 32'hFFFF8011, 2'b00, 32'h0000_0100, 4'b0000, 32'h0,        0);
    op("lb0",   0, 3'b000, 32'h0000_0100, 32'h0,        32'h80112233, 0, 32'h00000033, 2'b00, 32'h0000_0100, 4'b0000, 32'h0,        0);
    op("lh0",   0, 3'b001, 32'h0000_0000, 32'h0,        32'h8011A233, 1, 32'hFFFFA233, 2'b00, 32'h0000_0000, 4'b0000, 32'h0,        0);
    op("sb",    1, 3'b000, 32'h0000_0201, 32'h000000A5, 32'h0,        0, 32'h0,        2'b00, 32'h0000_0200, 4'b0010, 32'hA5A5A5A5, 0);
    op("sh",    1, 3'b001, 32'h0000_0202, 32'h0000BEEF, 32'h0,        1, 32'h0,        2'b00, 32'h0000_0200, 4'b1100, 32'hBEEFBEEF, 0);
    op("sw",    1, 3'b010, 32'h0000_0204, 32'h12345678, 32'h0,        0, 32'h0,        2'b00, 32'h0000_0204, 4'b1111, 32'h12345678, 0);
    op("sh_mis",1, 3'b001, 32'h0000_0203, 32'h0000BEEF, 32'h0,        0, 32'h0,        2'b01, 32'h0,         4'b0000, 32'h0,        0);
    op("lw_mis",0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        0, 32'h0,        2'b01, 32'h0,         4'b0000, 32'h0,        0);
    op("lh_mis",0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        0, 32'h0,        2'b01, 32'h0,         4'b0000, 32'h0,        0);
    op("f3_011",0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        0, 32'h0,        2'b10, 32'h0,         4'b0000, 32'h0,        0);
    op("sbu",   1, 3'b100, 32'h0000_0100, 32'h0,        32'h0,        0, 32'h0,        2'b10, 32'h0,         4'b0000, 32'h0,        0);
    op("f3_110",0, 3'b110, 32'h0000_0100, 32'h0,        32'h0,        0, 32'h0,        2'b10, 32'h0,         4'b0000, 32'h0,        0);
    op("lw_ok", 0, 3'b010, 32'h0000_0108, 32'h0,        32'hCAFE0001, 0, 32'hCAFE0001, 2'b00, 32'h0000_0108, 4'b0000, 32'h0,        0);
    op("tmo",   0, 3'b010, 32'h0000_0100, 32'h0,        32'h0,       -1, 32'h0,        2'b11, 32'h0000_0100, 4'b0000, 32'h0,        1);

    // Reset withdrawn mid-request
    @(negedge clk);
    i_start = 1'b1; i_is_store = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0000_0400;
    @(negedge clk);
    i_start = 1'b0; i_mem_ack = 1'b0;
    check_eq("arst/req_before", o_mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst/mem_req", o_mem_req, 1'b0);
    check_eq("arst/busy", o_busy, 1'b0);
    check_eq("arst/done", o_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    last_ld = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("arst/no_done", o_done, 1'b0);
      check_eq("arst/no_req", o_mem_req, 1'b0);
    end
    op("lw_post", 0, 3'b010, 32'h0000_0100, 32'h0, 32'h0BADF00D, 0, 32'h0BADF00D, 2'b00,
       32'h0000_0100, 4'b0000, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
